bnnseq_sample_feeder: RTL and testbench
=======================================

# bnnseq_sample_feeder

Upstream sequencer for the sequential binarized classifier `cardio_bnn1_bnnseq`. It accepts one feature nibble per handshake and assembles a full `FEAT_BITS*FEAT_CNT` sample. It then drives the classifier's reset and features, counts the classifier's fixed compute latency, and captures `prediction`. The result is presented on a valid/ready output, so a host or UART bridge can stream samples without knowing classifier timing.

## Interface
- `FEAT_CNT`, 19: features per sample.
- `FEAT_BITS`, 4: bits per feature.
- `HIDDEN_CNT`, 40: hidden neurons of the classifier; sets compute latency.
- `CLASS_CNT`, 3: classes; `CLS_W = $clog2(CLASS_CNT)`.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  feature beat valid.
- `in_data`  in  FEAT_BITS  feature value.
- `in_last`  in  1  marks final beat of a frame.
- `in_ready`  out  1  feeder accepts a beat.
- `bnn_features`  out  FEAT_BITS*FEAT_CNT  to classifier `features`.
- `bnn_rst`  out  1  to classifier `rst` (active-high).
- `bnn_prediction`  in  CLS_W  from classifier `prediction`.
- `res_valid`  out  1  result valid.
- `res_data`  out  CLS_W  captured class.
- `res_ready`  in  1  consumer accepts result.
- `frame_err`  out  1  one-cycle pulse on a malformed frame.

## Operation
- States: `LOAD`, `RESET`, `RUN`, `RESULT`. Reset state is `LOAD`.
- `LOAD`:
  - `in_ready=1`, `bnn_rst=1`.
  - On each accepted beat (`in_valid & in_ready`), shift left by FEAT_BITS and insert `in_data` at the LSB.
  - The first beat ends up at bits `[FEAT_BITS*FEAT_CNT-1 -: FEAT_BITS]`, which is memh text order.
  - Beat counter `beat_cnt` (width `$clog2(FEAT_CNT)`) increments per accepted beat.
- Frame completion:
  - Beat with `in_last=1` and `beat_cnt==FEAT_CNT-1`: go to `RESET`.
  - Beat with `in_last=1` and `beat_cnt!=FEAT_CNT-1`, or beat with `beat_cnt==FEAT_CNT-1` and `in_last=0`:
    - pulse `frame_err`;
    - clear `beat_cnt`;
    - stay in `LOAD`;
    - discard the shift register contents (need not clear).
- `RESET`: exactly one cycle, `bnn_rst=1`, `bnn_features` holds the complete sample. Next state `RUN`; load `run_cnt` with 0.
- `RUN`:
  - `bnn_rst=0`; `run_cnt` increments each cycle.
  - After `RUN_CYCLES = FEAT_CNT+HIDDEN_CNT` cycles (59 by default), latch `bnn_prediction` into `res_data` on the closing edge and go to `RESULT`.
- `RESULT`:
  - `res_valid=1`, `bnn_rst=1`, `in_ready=0`.
  - On `res_valid & res_ready`, go to `LOAD` and clear `beat_cnt`.
  - `res_data` holds until the next capture.
- `bnn_features` changes only in `LOAD`. It is stable through `RESET` and `RUN`.
- `in_valid` outside `LOAD` is ignored; no beat is consumed.

## Timing
- Reset values (while `rst_n=0`):
  - state `LOAD`; `beat_cnt=0`; `run_cnt=0`;
  - `bnn_features=0`; `res_data=0`;
  - `in_ready=1` after release (0 during reset); `bnn_rst=1`; `res_valid=0`; `frame_err=0`.
- All outputs are registered or decoded from state only; there is no combinational input→output path. `in_ready` depends on state, not on `in_valid`.
- Final beat accepted on edge at cycle t:
  - t+1: `RESET`.
  - t+2 … t+60: `RUN`.
  - t+61: `res_valid=1`.
  - Latency from last beat to result is 61 cycles, i.e. `RUN_CYCLES+2`.
- Result handshake completes at cycle r: `in_ready=1` at r+1. No zero-bubble overlap between frames.
- `rst_n` asserted mid-`RUN` or mid-`RESULT`:
  - immediate return to reset values;
  - the pending result is lost;
  - `bnn_rst` goes to 1 asynchronously.
- `res_ready` held high before `res_valid`: the handshake completes on the first `RESULT` cycle.

## Structure
- Shared package `bnnseq_pkg`:
  - state enum `feeder_state_t` (`LOAD`, `RESET`, `RUN`, `RESULT`);
  - function `run_cycles(feat_cnt, hidden_cnt)`;
  - `CLS_W` helper.
- One natural sub-module: `bnnseq_nibble_shreg`, a parameterized shift-in register with load-enable. The FSM and counters stay in the top.

## Test plan
- Nominal frame, 19 beats `in_data=0x1,0x2,…,0xF,0x0,0x1,0x2,0x3`, `in_last` on beat 19:
  - `bnn_features=76'h123456789ABCDEF0123`;
  - `bnn_rst` low for exactly 59 cycles;
  - with a stub classifier driving `bnn_prediction=2` during `RUN`, `res_valid` at t+61 and `res_data=2`.
- Backpressure: `res_ready=0` for 10 cycles after `res_valid`.
  - `res_valid` and `res_data` stay stable; `in_ready=0`.
  - `in_valid=1` beats are not consumed.
- Short frame: `in_last` on beat 5.
  - `frame_err` pulses once; no `RESET`/`RUN` occurs.
  - A following correct 19-beat frame yields a normal result.
- Missing `in_last` on beat 19:
  - `frame_err` pulses; state stays `LOAD`; `bnn_rst` stays 1.
- `rst_n` pulsed low at `RUN` cycle 30:
  - all outputs return to reset values; no `res_valid`;
  - the next frame completes with the correct latency.
- Back-to-back: three frames against the real `cardio_bnn1_bnnseq` using the first three `cardio.memh` vectors.
  - Each prediction matches the standalone classifier result for that vector.
  - Frame spacing is 19 + 61 + 1 cycles when `res_ready=1`.

Source files
------------

// File: rtl/bnnseq_pkg.sv
// Shared types and helpers for the sequential BNN sample feeder.
package bnnseq_pkg;

   // Feeder control states
   typedef enum logic [1:0] {
      LOAD,
      RESET,
      RUN,
      RESULT
   } feeder_state_t;

   // Classifier compute latency in clock cycles once its reset is released
   function automatic int unsigned run_cycles(input int unsigned feat_cnt,
                                              input int unsigned hidden_cnt);
      return feat_cnt + hidden_cnt;
   endfunction

   // Width of a class index; never narrower than one bit
   function automatic int unsigned cls_w(input int unsigned class_cnt);
      return (class_cnt > 1) ? $clog2(class_cnt) : 1;
   endfunction

endpackage

// File: rtl/bnnseq_nibble_shreg.sv
// Shift-in register: each enabled cycle shifts left by WIDTH and inserts din at the LSB,
// so the first value written ends up in the most significant slot.
module bnnseq_nibble_shreg #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned DEPTH = 19  // must be at least 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     load_en,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH*DEPTH-1:0]   dout
);

   logic [WIDTH*DEPTH-1:0] data_q;

   // Shift in one value per enabled cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
      end else if (load_en) begin
         data_q <= {data_q[WIDTH*(DEPTH-1)-1:0], din};
      end
   end

   assign dout = data_q;

endmodule

// File: rtl/bnnseq_sample_feeder.sv
// Collects one feature per handshake into a full sample, sequences the classifier through
// reset and its fixed compute latency, then offers the prediction on a valid/ready port.
module bnnseq_sample_feeder
   import bnnseq_pkg::*;
#(
   parameter int unsigned FEAT_CNT   = 19,
   parameter int unsigned FEAT_BITS  = 4,
   parameter int unsigned HIDDEN_CNT = 40,
   parameter int unsigned CLASS_CNT  = 3,
   parameter int unsigned CLS_W      = cls_w(CLASS_CNT)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   input  logic [FEAT_BITS-1:0]          in_data,
   input  logic                          in_last,
   output logic                          in_ready,
   output logic [FEAT_BITS*FEAT_CNT-1:0] bnn_features,
   output logic                          bnn_rst,
   input  logic [CLS_W-1:0]              bnn_prediction,
   output logic                          res_valid,
   output logic [CLS_W-1:0]              res_data,
   input  logic                          res_ready,
   output logic                          frame_err
);

   localparam int unsigned RUN_CYCLES = run_cycles(FEAT_CNT, HIDDEN_CNT);
   localparam int unsigned BEAT_W     = $clog2(FEAT_CNT);
   localparam int unsigned RUN_W      = $clog2(RUN_CYCLES);

   feeder_state_t state_q, state_d;
   logic [BEAT_W-1:0] beat_cnt_q;
   logic [RUN_W-1:0]  run_cnt_q;
   logic [CLS_W-1:0]  res_data_q;
   logic              frame_err_q;
   logic              in_ready_q;

   logic accept;
   logic last_beat;
   logic run_done;
   logic frame_ok;
   logic frame_bad;

   // in_ready_q is only ever set while in LOAD, so it alone qualifies a beat
   assign accept    = in_valid & in_ready_q;
   assign last_beat = (beat_cnt_q == BEAT_W'(FEAT_CNT - 1));
   assign run_done  = (run_cnt_q == RUN_W'(RUN_CYCLES - 1));
   assign frame_ok  = accept & in_last & last_beat;
   assign frame_bad = accept & (in_last ^ last_beat);

   bnnseq_nibble_shreg #(
      .WIDTH (FEAT_BITS),
      .DEPTH (FEAT_CNT)
   ) u_shreg (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_en (accept),
      .din     (in_data),
      .dout    (bnn_features)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= LOAD;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         LOAD:    if (frame_ok) state_d = RESET;
         RESET:   state_d = RUN;
         RUN:     if (run_done) state_d = RESULT;
         RESULT:  if (res_ready) state_d = LOAD;
         default: state_d = LOAD;
      endcase
   end

   // Output decode: classifier held in reset except while it computes
   always_comb begin
      bnn_rst   = 1'b1;
      res_valid = 1'b0;
      unique case (state_q)
         LOAD:    bnn_rst = 1'b1;
         RESET:   bnn_rst = 1'b1;
         RUN:     bnn_rst = 1'b0;
         RESULT:  res_valid = 1'b1;
         default: bnn_rst = 1'b1;
      endcase
   end

   // Counters, result capture, error pulse and registered in_ready
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_cnt_q  <= '0;
         run_cnt_q   <= '0;
         res_data_q  <= '0;
         frame_err_q <= 1'b0;
         in_ready_q  <= 1'b0;
      end else begin
         frame_err_q <= frame_bad;
         // Registered from next state so in_ready never depends on in_valid
         in_ready_q  <= (state_d == LOAD);
         if (accept) begin
            // Any frame end, good or malformed, restarts the beat count
            if (in_last || last_beat) begin
               beat_cnt_q <= '0;
            end else begin
               beat_cnt_q <= beat_cnt_q + 1'b1;
            end
         end else if (state_q == RESULT && res_ready) begin
            beat_cnt_q <= '0;
         end
         if (state_q == RESET) begin
            run_cnt_q <= '0;
         end else if (state_q == RUN && !run_done) begin
            run_cnt_q <= run_cnt_q + 1'b1;
         end
         if (state_q == RUN && run_done) begin
            res_data_q <= bnn_prediction;
         end
      end
   end

   assign in_ready  = in_ready_q;
   assign res_data  = res_data_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_bnnseq_sample_feeder.sv
// Directed bench for bnnseq_sample_feeder with a stub classifier.
module tb_bnnseq_sample_feeder;

   localparam int unsigned FEAT_CNT  = 19;
   localparam int unsigned FEAT_BITS = 4;
   localparam int unsigned FW        = FEAT_CNT * FEAT_BITS;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic [3:0]    in_data;
   logic          in_last;
   logic          in_ready;
   logic [FW-1:0] bnn_features;
   logic          bnn_rst;
   logic [1:0]    bnn_prediction;
   logic          res_valid;
   logic [1:0]    res_data;
   logic          res_ready;
   logic          frame_err;
   logic [1:0]    stub_class;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int err_pulses = 0;
   int first_edge = 0;
   int last_edge = 0;

   always #5 clk = ~clk;

   // Stub classifier: a fixed class while out of reset
   assign bnn_prediction = bnn_rst ? 2'd0 : stub_class;

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (frame_err) err_pulses <= err_pulses + 1;

   bnnseq_sample_feeder dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_valid       (in_valid),
      .in_data        (in_data),
      .in_last        (in_last),
      .in_ready       (in_ready),
      .bnn_features   (bnn_features),
      .bnn_rst        (bnn_rst),
      .bnn_prediction (bnn_prediction),
      .res_valid      (res_valid),
      .res_data       (res_data),
      .res_ready      (res_ready),
      .frame_err      (frame_err)
   );

   task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Hold a beat until it is accepted; returns at #1 after the accepting edge
   task automatic send_beat(input logic [3:0] d, input logic l);
      bit ok;
      ok = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      for (int n = 0; n < 300 && !ok; n++) begin
         if (in_ready) ok = 1'b1;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      last_edge = cyc;
      if (!ok) check("beat_timeout", FW'(0), FW'(1));
   endtask

   task automatic send_frame(input logic [FW-1:0] vec, input int n_beats, input int last_at);
      for (int i = 0; i < n_beats; i++) begin
         send_beat(vec[FW-1-4*i -: 4], (i == last_at));
         if (i == 0) first_edge = last_edge;
      end
   endtask

   // Complete frame: checks features, latency, bnn_rst low time and the captured class
   task automatic full_frame(input logic [FW-1:0] vec, input logic [1:0] cls);
      int lat;
      int low;
      stub_class = cls;
      send_frame(vec, FEAT_CNT, FEAT_CNT - 1);
      check("feat_in_reset", bnn_features, vec);
      check("rst_in_reset", FW'(bnn_rst), FW'(1));
      lat = 1;
      low = 0;
      while (!res_valid && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
         if (!bnn_rst) low++;
      end
      check("latency", FW'(lat), FW'(61));
      check("rst_low_cycles", FW'(low), FW'(59));
      check("res_data", FW'(res_data), FW'(cls));
      check("feat_hold", bnn_features, vec);
   endtask

   task automatic take_result();
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      res_ready = 1'b0;
      check("ready_after_hs", FW'(in_ready), FW'(1));
   endtask

   initial begin
      logic [FW-1:0] vecs [3];
      logic [1:0]    cls [3];
      int            e0;
      int            bad;
      int            low;
      int            prev_last;

      vecs[0] = 76'h0F1E2D3C4B5A6978876;
      vecs[1] = 76'hFFFFFFFFFFFFFFFFFFF;
      vecs[2] = 76'h8000000000000000001;
      cls[0] = 2'd1;
      cls[1] = 2'd0;
      cls[2] = 2'd2;

      rst_n = 1'b0;
      in_valid = 1'b0;
      in_data = '0;
      in_last = 1'b0;
      res_ready = 1'b0;
      stub_class = 2'd2;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", FW'(in_ready), FW'(0));
      check("rst_bnn_rst", FW'(bnn_rst), FW'(1));
      check("rst_res_valid", FW'(res_valid), FW'(0));
      check("rst_frame_err", FW'(frame_err), FW'(0));
      check("rst_features", bnn_features, FW'(0));
      check("rst_res_data", FW'(res_data), FW'(0));
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("release_in_ready", FW'(in_ready), FW'(1));

      // Nominal frame
      full_frame(76'h123456789ABCDEF0123, 2'd2);

      // Backpressure: result held, beats ignored
      in_valid = 1'b1;
      in_data  = 4'h5;
      bad = 0;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (!res_valid || res_data !== 2'd2 || in_ready) bad++;
      end
      check("bp_stable", FW'(bad), FW'(0));
      in_valid = 1'b0;
      take_result();
      check("bp_valid_drop", FW'(res_valid), FW'(0));

      // Short frame
      e0 = err_pulses;
      send_frame(76'hABCDE00000000000000, 5, 4);
      check("short_err_pulse", FW'(frame_err), FW'(1));
      low = 0;
      bad = 0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (!bnn_rst) low++;
         if (res_valid) bad++;
      end
      check("short_pulses", FW'(err_pulses - e0), FW'(1));
      check("short_no_run", FW'(low), FW'(0));
      check("short_no_result", FW'(bad), FW'(0));
      full_frame(76'h0123456789ABCDEF012, 2'd0);
      take_result();

      // Missing in_last on the final beat
      e0 = err_pulses;
      send_frame(76'h5555555555555555555, FEAT_CNT, -1);
      check("miss_err_pulse", FW'(frame_err), FW'(1));
      check("miss_bnn_rst", FW'(bnn_rst), FW'(1));
      check("miss_in_ready", FW'(in_ready), FW'(1));
      repeat (5) @(posedge clk);
      #1;
      check("miss_pulses", FW'(err_pulses - e0), FW'(1));
      check("miss_no_result", FW'(res_valid), FW'(0));
      full_frame(76'hFEDCBA9876543210FED, 2'd1);
      take_result();

      // Reset asserted in the middle of RUN
      stub_class = 2'd2;
      send_frame(76'h3141592653589793238, FEAT_CNT, FEAT_CNT - 1);
      repeat (30) @(posedge clk);
      #1;
      check("mid_run_active", FW'(bnn_rst), FW'(0));
      #2 rst_n = 1'b0;
      #1;
      check("arst_bnn_rst", FW'(bnn_rst), FW'(1));
      check("arst_res_valid", FW'(res_valid), FW'(0));
      check("arst_in_ready", FW'(in_ready), FW'(0));
      check("arst_features", bnn_features, FW'(0));
      check("arst_res_data", FW'(res_data), FW'(0));
      @(negedge clk) rst_n = 1'b1;
      bad = 0;
      repeat (80) begin
         @(posedge clk);
         #1;
         if (res_valid) bad++;
      end
      check("arst_no_result", FW'(bad), FW'(0));
      full_frame(76'h2718281828459045235, 2'd2);
      take_result();

      // Back-to-back frames with res_ready held high
      res_ready = 1'b1;
      prev_last = 0;
      for (int k = 0; k < 3; k++) begin
         full_frame(vecs[k], cls[k]);
         if (k > 0) check("b2b_gap", FW'(first_edge - prev_last), FW'(62));
         prev_last = last_edge;
      end
      @(posedge clk);
      #1;
      res_ready = 1'b0;
      check("b2b_done_ready", FW'(in_ready), FW'(1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
